serial_adder_ctrl: RTL and testbench
====================================

# serial_adder_ctrl

Bit-serial multi-bit adder controller built around a single `fulladder` instance. It accepts two WIDTH-bit operands and a carry-in over a valid/ready handshake. It then steps the fulladder through the operands LSB-first, one bit per clock, holding the running carry in a register. The result is presented on a valid/ready output handshake. It is an area-minimal alternative to a ripple-carry adder for the homework datapath, and trades WIDTH cycles of latency for one adder cell.

## Interface
- `WIDTH`, default 8, operand/result width in bits; legal range WIDTH >= 2.
- `clk`  input  1  rising-edge clock, single clock domain.
- `rst_n`  input  1  reset, synchronous, active-low.
- `in_valid`  input  1  operands valid.
- `in_ready`  output  1  block can accept operands.
- `a`  input  WIDTH  operand A, sampled on input handshake.
- `b`  input  WIDTH  operand B, sampled on input handshake.
- `c_in`  input  1  carry-in, sampled on input handshake.
- `out_valid`  output  1  result valid.
- `out_ready`  input  1  consumer accepts result.
- `sum`  output  WIDTH  result bits, a + b + c_in mod 2^WIDTH.
- `c_out`  output  1  final carry-out.
- `busy`  output  1  high in RUN or DONE.

## Operation
- States: IDLE, RUN, DONE.
- IDLE:
  - `in_ready`=1.
  - On `in_valid`&&`in_ready`: load the shift registers `a_sr`<=`a` and `b_sr`<=`b`, set the carry register `cy`<=`c_in`, `bit_cnt`<=0, `sum_sr`<=0, and move to RUN.
- RUN:
  - `in_ready`=0. `a` and `b` are ignored.
  - Each cycle the fulladder sees `a_sr[0]`, `b_sr[0]` and `cy`.
  - At the clock edge: `a_sr` and `b_sr` shift right by 1. `sum_sr` shifts right, with the fulladder `sum` entering the MSB. `cy`<=the fulladder `c_out`. `bit_cnt`++.
  - When `bit_cnt`==WIDTH-1 at the edge, move to DONE.
- DONE:
  - `out_valid`=1. `sum`=`sum_sr`, `c_out`=`cy`, both stable.
  - On `out_valid`&&`out_ready`, move to IDLE.
  - While `out_ready`=0, all outputs hold indefinitely.
- `sum` and `c_out` are driven from registers in every state. Outside DONE they hold the last result, or 0 after reset.
- `bit_cnt` width is $clog2(WIDTH). No wrap occurs because the exit happens at WIDTH-1.
- Reset (`rst_n`=0 at any edge, including mid-RUN or in DONE):
  - State is IDLE and all registers are 0.
  - `in_ready`=1, `out_valid`=0, `sum`=0, `c_out`=0, `busy`=0.
  - In-flight operation is discarded.
  - Reset takes priority over the handshakes.
- No overlap: a new input is never accepted in RUN or DONE.

## Timing
- The input handshake at edge k makes RUN active for cycles k+1 .. k+WIDTH.
- Bit i is computed in cycle k+1+i and registered at the end of that cycle.
- `out_valid` rises in cycle k+WIDTH+1, so latency is WIDTH+1 cycles from acceptance to result.
- An output handshake at edge m gives `in_ready`=1 in cycle m+1.
- Minimum initiation interval is WIDTH+2 cycles.
- `in_ready`, `out_valid` and `busy` are pure state decodes, with no combinational path from `in_valid` or `out_ready`.

## Structure
- Package `serial_adder_pkg`:
  - `typedef enum logic [1:0] {IDLE, RUN, DONE} state_t`.
  - Default width constant `SA_WIDTH_DEFAULT` = 8.
- Sub-module: exactly one `fulladder` instance, named `u_fa`. No other arithmetic in the block.
- One `always_ff` for state and datapath registers, one `always_comb` for next-state logic.

## Test plan
All scenarios use WIDTH=8.
1. Reset then idle: hold `rst_n`=0 for 2 cycles -> `in_ready`=1, `out_valid`=0, `sum`=0x00, `c_out`=0, `busy`=0.
2. Carry ripple: a=0xFF, b=0x01, c_in=0 -> after 9 cycles `out_valid`=1, `sum`=0x00, `c_out`=1.
3. Carry-in use: a=0x5A, b=0x3C, c_in=1 -> `sum`=0x97, `c_out`=0; `out_valid` first seen exactly 9 cycles after acceptance.
4. Backpressure and ignored input:
   - With a=0x80, b=0x80, c_in=0, toggle `in_valid` with new operands during RUN -> the toggled operands are not accepted.
   - Hold `out_ready`=0 for 5 cycles in DONE -> `sum`=0x00 and `c_out`=1 stay stable throughout.
   - Raise `out_ready` -> IDLE next cycle.
5. Reset mid-operation: assert `rst_n`=0 at bit 4 of a RUN -> next cycle IDLE with all outputs 0. A following a=0x01, b=0x02, c_in=0 -> `sum`=0x03, `c_out`=0.
6. Back-to-back: keep `in_valid`=1 and `out_ready`=1 with 0x10+0x20 then 0xF0+0x20 -> results 0x30/`c_out`=0 and 0x10/`c_out`=1, with accept edges 10 cycles apart.

Source files
------------

// File: rtl/serial_adder_pkg.sv
// Shared types and constants for the bit-serial adder controller.
// Imported by serial_adder_ctrl and by anything that needs its state encoding.
package serial_adder_pkg;

    localparam int SA_WIDTH_DEFAULT = 8;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

endpackage

// File: rtl/serial_adder_ctrl_fa.sv
// Single-bit full adder cell.
// The serial controller steps through the operands with this one cell.
module fulladder (
    input  logic a,
    input  logic b,
    input  logic c_in,
    output logic sum,
    output logic c_out
);

    assign sum   = a ^ b ^ c_in;
    assign c_out = (a & b) | (c_in & (a ^ b));

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial WIDTH-bit adder: one full adder cell, LSB first, one bit per clock.
// Operands arrive over a valid/ready handshake and the result leaves over another.
module serial_adder_ctrl
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = SA_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             busy
);

    localparam int                CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] sum_sr;
    logic [WIDTH-1:0] sum_q;
    logic             cy;
    logic             c_out_q;
    logic [CNT_W-1:0] bit_cnt;
    logic             fa_sum;
    logic             fa_cout;
    logic             last_bit;

    fulladder u_fa (
        .a     (a_sr[0]),
        .b     (b_sr[0]),
        .c_in  (cy),
        .sum   (fa_sum),
        .c_out (fa_cout)
    );

    assign last_bit = (bit_cnt == LAST_BIT);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid)  state_nxt = RUN;
            RUN:     if (last_bit)  state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // The published result lives in sum_q/c_out_q so it stays put while the
    // next operation reuses sum_sr and cy as scratch.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            a_sr    <= '0;
            b_sr    <= '0;
            sum_sr  <= '0;
            sum_q   <= '0;
            cy      <= 1'b0;
            c_out_q <= 1'b0;
            bit_cnt <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_sr    <= a;
                        b_sr    <= b;
                        cy      <= c_in;
                        bit_cnt <= '0;
                        sum_sr  <= '0;
                    end
                end
                RUN: begin
                    a_sr   <= a_sr >> 1;
                    b_sr   <= b_sr >> 1;
                    sum_sr <= {fa_sum, sum_sr[WIDTH-1:1]};
                    cy     <= fa_cout;
                    if (last_bit) begin
                        sum_q   <= {fa_sum, sum_sr[WIDTH-1:1]};
                        c_out_q <= fa_cout;
                    end else begin
                        bit_cnt <= bit_cnt + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);
    assign sum       = sum_q;
    assign c_out     = c_out_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Scoreboard bench for serial_adder_ctrl: accepted operands push a + b + c_in,
// a negedge monitor pops and compares whenever a result is handed off.
module tb_serial_adder_ctrl;

    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] a = '0;
    logic [WIDTH-1:0] b = '0;
    logic             c_in = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [WIDTH-1:0] sum;
    logic             c_out;
    logic             busy;

    int n_checks = 0;
    int n_errors = 0;
    int edge_cnt = 0;
    bit rand_bp = 1'b0;
    bit prev_ov = 1'b0;

    logic [WIDTH:0] exp_q[$];
    int             acc_q[$];
    int             accept_log[$];

    serial_adder_ctrl #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .c_in      (c_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .c_out     (c_out),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (edge %0d)",
                     name, actual, expected, edge_cnt);
        end
    endtask

    task automatic reportTimeout(input string name);
        n_checks++;
        n_errors++;
        $display("[TB] FAIL %s: timed out waiting for DUT (edge %0d)", name, edge_cnt);
    endtask

    // Reference: plain integer addition of whatever was actually accepted.
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            acc_q.delete();
            prev_ov = 1'b0;
        end else begin
            if (in_valid && in_ready) begin
                exp_q.push_back({1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, c_in});
                acc_q.push_back(edge_cnt + 1);
                accept_log.push_back(edge_cnt + 1);
            end
            if (out_valid && !prev_ov) begin
                if (acc_q.size() == 0)
                    reportTimeout("spurious_out_valid");
                else
                    checkOutput("latency_edges", edge_cnt - acc_q.pop_front(), WIDTH);
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    reportTimeout("result_without_operands");
                end else begin
                    logic [WIDTH:0] e;
                    e = exp_q.pop_front();
                    checkOutput("sum", sum, e[WIDTH-1:0]);
                    checkOutput("c_out", c_out, e[WIDTH]);
                end
            end
            prev_ov = out_valid;
        end
    end

    task automatic applyStimulus(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                                 input logic cv, input bit hold_valid);
        @(posedge clk);
        #1;
        a = av;
        b = bv;
        c_in = cv;
        in_valid = 1'b1;
        for (int i = 0; i < 64; i++) begin
            if (rand_bp) out_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            if (in_ready && rst_n) begin
                @(posedge clk);
                #1;
                if (!hold_valid) in_valid = 1'b0;
                return;
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        reportTimeout("input_accept");
    endtask

    task automatic drain();
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && in_ready) begin
                @(posedge clk);
                #1;
                out_ready = 1'b1;
                return;
            end
            @(posedge clk);
            #1;
            if (rand_bp) out_ready = ($urandom_range(0, 3) != 0);
            else out_ready = 1'b1;
        end
        out_ready = 1'b1;
        reportTimeout("drain");
    endtask

    task automatic checkIdleOutputs(input string tag);
        checkOutput({tag, "_in_ready"}, in_ready, 1);
        checkOutput({tag, "_out_valid"}, out_valid, 0);
        checkOutput({tag, "_sum"}, sum, 0);
        checkOutput({tag, "_c_out"}, c_out, 0);
        checkOutput({tag, "_busy"}, busy, 0);
    endtask

    initial begin
        bit found;

        // Reset then idle
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkIdleOutputs("reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Carry ripple and carry-in use
        applyStimulus(8'hFF, 8'h01, 1'b0, 1'b0);
        drain();
        applyStimulus(8'h5A, 8'h3C, 1'b1, 1'b0);
        drain();

        // Backpressure with ignored operands during RUN
        out_ready = 1'b0;
        applyStimulus(8'h80, 8'h80, 1'b0, 1'b0);
        for (int i = 0; i < 7; i++) begin
            @(posedge clk);
            #1;
            in_valid = ~in_valid;
            a = 8'($urandom);
            b = 8'($urandom);
            c_in = 1'($urandom);
            @(negedge clk);
            checkOutput("run_in_ready", in_ready, 0);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            if (out_valid) found = 1'b1;
        end
        if (!found) reportTimeout("bp_out_valid");
        for (int i = 0; i < 5; i++) begin
            checkOutput("bp_out_valid", out_valid, 1);
            checkOutput("bp_sum", sum, 8'h00);
            checkOutput("bp_c_out", c_out, 1);
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checkOutput("bp_release_in_ready", in_ready, 1);
        checkOutput("bp_release_out_valid", out_valid, 0);

        // Reset in the middle of RUN, bit 4
        applyStimulus(8'h33, 8'h44, 1'b1, 1'b0);
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(negedge clk);
        checkOutput("midrun_busy", busy, 1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        checkIdleOutputs("midrun_reset");
        applyStimulus(8'h01, 8'h02, 1'b0, 1'b0);
        drain();

        // Back-to-back with in_valid and out_ready held high
        accept_log.delete();
        out_ready = 1'b1;
        applyStimulus(8'h10, 8'h20, 1'b0, 1'b1);
        applyStimulus(8'hF0, 8'h20, 1'b0, 1'b0);
        drain();
        if (accept_log.size() == 2)
            checkOutput("b2b_accept_spacing", accept_log[1] - accept_log[0], WIDTH + 2);
        else
            checkOutput("b2b_accept_count", accept_log.size(), 2);

        // Randomized operands with random output backpressure
        rand_bp = 1'b1;
        for (int i = 0; i < 40; i++) begin
            applyStimulus(8'($urandom), 8'($urandom), 1'($urandom), 1'b0);
        end
        drain();
        rand_bp = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        checkOutput("final_scoreboard_empty", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_errors);
        $finish;
    end

endmodule
